// File: rtl/coin_dispense_pkg.sv
// Shared types and constants for the coin dispense sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coin_dispense_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CAN    = 3'd1,
    SEL    = 3'd2,
    DIME   = 3'd3,
    NICKEL = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Coin values in nickel units.
  localparam int NICKEL_UNITS = 1;
  localparam int DIME_UNITS   = 2;

endpackage

// File: rtl/dispense_ack_timer.sv
// Counts cycles a dispense req has waited for its ack; flags the last allowed cycle.
// Latency: expired_o is combinational from the count, asserted in the ACK_TIMEOUT-th req cycle.
// Backpressure: none; the count saturates while run_i stays high.
module dispense_ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Restart on entry to a req state, otherwise count up while a req is high.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != CW'(ACK_TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The first req cycle sees count 0, so count ACK_TIMEOUT-1 is the last one.
  assign expired_o = run_i && (cnt_q == CW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/coin_dispense_ctrl.sv
// Dispenses a can then greedy dime/nickel change over req/ack handshakes; optional ack timeout via COIN_DISPENSE_TIMEOUT_EN.
// Latency: accept to can_req is 1 cycle; ack to next req is 2 cycles; all outputs registered.
// Backpressure: vend_ready is high only in IDLE; vend_valid while busy is dropped.
module coin_dispense_ctrl
  import coin_dispense_pkg::*;
#(
  parameter int CREDIT_W    = 8,
  parameter int PRICE_N     = 5,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vend_valid,
  input  logic [CREDIT_W-1:0] credit_n,
  output logic                vend_ready,
  output logic                can_req,
  input  logic                can_ack,
  output logic                dime_req,
  input  logic                dime_ack,
  input  logic                dime_empty,
  output logic                nickel_req,
  input  logic                nickel_ack,
  input  logic                nickel_empty,
  output logic                busy,
  output logic                done,
  output logic [CREDIT_W-1:0] short_n,
  output logic                fault
);

  localparam logic [CREDIT_W-1:0] PRICE  = CREDIT_W'(PRICE_N);
  localparam logic [CREDIT_W-1:0] DIME_C = CREDIT_W'(DIME_UNITS);
  localparam logic [CREDIT_W-1:0] NICK_C = CREDIT_W'(NICKEL_UNITS);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [CREDIT_W-1:0] short_q, short_d;
  logic                fault_q, fault_d;
  logic                can_req_q, dime_req_q, nickel_req_q;
  logic                vend_ready_q, busy_q, done_q;
  logic                timeout_hit;

`ifdef COIN_DISPENSE_TIMEOUT_EN
  logic timer_load;
  logic any_req;

  assign any_req    = can_req_q | dime_req_q | nickel_req_q;
  assign timer_load = (state_d != state_q) &&
                      ((state_d == CAN) || (state_d == DIME) || (state_d == NICKEL));

  dispense_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (timer_load),
    .run_i     (any_req),
    .expired_o (timeout_hit)
  );
`else
  logic unused_ack_timeout;

  assign timeout_hit        = 1'b0;
  assign unused_ack_timeout = (ACK_TIMEOUT == 0);
`endif

  // Next state, change bookkeeping and shortfall/fault updates.
  always_comb begin
    state_d  = state_q;
    change_d = change_q;
    short_d  = short_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        if (vend_valid && vend_ready_q) begin
          short_d = '0;
          if (credit_n >= PRICE) begin
            change_d = credit_n - PRICE;
            state_d  = CAN;
          end else begin
            change_d = credit_n;
            state_d  = SEL;
          end
        end
      end
      CAN: begin
        if (can_ack && can_req_q) begin
          state_d = SEL;
        end else if (timeout_hit) begin
          // The can was never delivered, so its price is owed back too.
          state_d = DONE;
          fault_d = 1'b1;
          short_d = change_q + PRICE;
        end
      end
      SEL: begin
        if (change_q == '0) begin
          state_d = DONE;
        end else if ((change_q >= DIME_C) && !dime_empty) begin
          state_d = DIME;
        end else if (!nickel_empty) begin
          state_d = NICKEL;
        end else begin
          state_d = DONE;
          short_d = change_q;
        end
      end
      DIME: begin
        if (dime_ack && dime_req_q) begin
          change_d = change_q - DIME_C;
          state_d  = SEL;
        end else if (timeout_hit) begin
          state_d = DONE;
          fault_d = 1'b1;
          short_d = change_q;
        end
      end
      NICKEL: begin
        if (nickel_ack && nickel_req_q) begin
          change_d = change_q - NICK_C;
          state_d  = SEL;
        end else if (timeout_hit) begin
          state_d = DONE;
          fault_d = 1'b1;
          short_d = change_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      change_q     <= '0;
      short_q      <= '0;
      fault_q      <= 1'b0;
      can_req_q    <= 1'b0;
      dime_req_q   <= 1'b0;
      nickel_req_q <= 1'b0;
      vend_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      change_q     <= change_d;
      short_q      <= short_d;
      fault_q      <= fault_d;
      can_req_q    <= (state_d == CAN);
      dime_req_q   <= (state_d == DIME);
      nickel_req_q <= (state_d == NICKEL);
      vend_ready_q <= (state_d == IDLE);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
    end
  end

  assign vend_ready = vend_ready_q;
  assign can_req    = can_req_q;
  assign dime_req   = dime_req_q;
  assign nickel_req = nickel_req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign short_n    = short_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_coin_dispense_ctrl.sv
// Directed bench for coin_dispense_ctrl: handshake counts, cycle timing, shortfall, reset, timeout.
// Latency: n/a.
// Backpressure: ack responder raises ack after a programmable wait.
module tb_coin_dispense_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       vend_valid;
  logic [7:0] credit_n;
  logic       vend_ready;
  logic       can_req, can_ack;
  logic       dime_req, dime_ack, dime_empty;
  logic       nickel_req, nickel_ack, nickel_empty;
  logic       busy, done, fault;
  logic [7:0] short_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coin_dispense_ctrl #(.CREDIT_W(8), .PRICE_N(5), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .vend_valid(vend_valid), .credit_n(credit_n),
    .vend_ready(vend_ready), .can_req(can_req), .can_ack(can_ack),
    .dime_req(dime_req), .dime_ack(dime_ack), .dime_empty(dime_empty),
    .nickel_req(nickel_req), .nickel_ack(nickel_ack), .nickel_empty(nickel_empty),
    .busy(busy), .done(done), .short_n(short_n), .fault(fault)
  );

  // Results of the most recent transaction.
  int         r_can, r_dime, r_nick, r_done, r_done_at;
  logic [7:0] r_short, r_short1;
  logic       r_ovl, r_rdy_after, r_done_after, r_fault;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one vend, answers reqs after aw waiting cycles, and records what happened.
  // vv_cyc > 0 pulses vend_valid (credit 20) in that cycle of the run.
  task automatic run_txn(input logic [7:0] credit, input logic de, input logic ne,
                         input int aw, input int vv_cyc);
    int w;
    w = 0;
    r_can = 0; r_dime = 0; r_nick = 0; r_done = 0; r_done_at = -1;
    r_short = '0; r_short1 = 8'hff; r_ovl = 1'b0; r_rdy_after = 1'b0;
    r_done_after = 1'b1; r_fault = 1'b0;
    dime_empty = de; nickel_empty = ne;
    vend_valid = 1'b1; credit_n = credit;
    step();
    vend_valid = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (r_done_at >= 0) begin
        r_rdy_after  = vend_ready;
        r_done_after = done;
        break;
      end
      if (cyc == 1) r_short1 = short_n;
      if (int'(can_req) + int'(dime_req) + int'(nickel_req) > 1) r_ovl = 1'b1;
      if (can_req) r_can++;
      vend_valid = (cyc == vv_cyc);
      credit_n   = (cyc == vv_cyc) ? 8'd20 : credit;
      can_ack = 1'b0; dime_ack = 1'b0; nickel_ack = 1'b0;
      if (can_req || dime_req || nickel_req) begin
        w++;
        if (w > aw) begin
          can_ack = can_req; dime_ack = dime_req; nickel_ack = nickel_req;
          r_dime += int'(dime_req);
          r_nick += int'(nickel_req);
        end
      end else begin
        w = 0;
      end
      if (done) begin
        r_done++;
        if (r_done_at < 0) begin
          r_done_at = cyc; r_short = short_n; r_fault = fault;
        end
      end
      step();
    end
    can_ack = 1'b0; dime_ack = 1'b0; nickel_ack = 1'b0; vend_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (vend_ready !== 1'b1) begin errors++; $display("FAIL reset_vend_ready: got %b expected 1", vend_ready); end
    checks++; if ({can_req, dime_req, nickel_req, busy, done, fault} !== 6'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 000000", {can_req, dime_req, nickel_req, busy, done, fault}); end
    checks++; if (short_n !== 8'd0) begin errors++; $display("FAIL reset_short: got %0d expected 0", short_n); end
    reset = 1'b0;
    // Acks while no req is outstanding must not move the block.
    can_ack = 1'b1; dime_ack = 1'b1; nickel_ack = 1'b1;
    step(); step();
    checks++; if ({vend_ready, can_req, dime_req, nickel_req, busy} !== 5'b10000) begin errors++; $display("FAIL idle_ack_ignored: got %b expected 10000", {vend_ready, can_req, dime_req, nickel_req, busy}); end
    can_ack = 1'b0; dime_ack = 1'b0; nickel_ack = 1'b0;
    step();
  endtask

  task automatic test_exact_price();
    run_txn(8'd5, 1'b0, 1'b0, 0, 0);
    checks++; if (r_done_at !== 3) begin errors++; $display("FAIL exact_fast_done_at: got %0d expected 3", r_done_at); end
    checks++; if (r_rdy_after !== 1'b1 || r_done_after !== 1'b0) begin errors++; $display("FAIL exact_fast_idle: got rdy=%b done=%b expected rdy=1 done=0", r_rdy_after, r_done_after); end
    run_txn(8'd5, 1'b0, 1'b0, 2, 0);
    checks++; if (r_can !== 3) begin errors++; $display("FAIL exact_can_cycles: got %0d expected 3", r_can); end
    checks++; if (r_dime + r_nick !== 0) begin errors++; $display("FAIL exact_coins: got %0d expected 0", r_dime + r_nick); end
    checks++; if (r_done !== 1 || r_done_at !== 5) begin errors++; $display("FAIL exact_done: got count=%0d at=%0d expected count=1 at=5", r_done, r_done_at); end
    checks++; if (r_short !== 8'd0) begin errors++; $display("FAIL exact_short: got %0d expected 0", r_short); end
  endtask

  task automatic test_change();
    run_txn(8'd9, 1'b0, 1'b0, 0, 0);
    checks++; if (r_dime !== 2 || r_nick !== 0) begin errors++; $display("FAIL chg4_coins: got d=%0d n=%0d expected d=2 n=0", r_dime, r_nick); end
    checks++; if (r_done_at !== 7 || r_short !== 8'd0) begin errors++; $display("FAIL chg4_timing: got at=%0d short=%0d expected at=7 short=0", r_done_at, r_short); end
    run_txn(8'd8, 1'b1, 1'b0, 1, 0);
    checks++; if (r_dime !== 0 || r_nick !== 3) begin errors++; $display("FAIL chg3_noDime_coins: got d=%0d n=%0d expected d=0 n=3", r_dime, r_nick); end
    checks++; if (r_done_at !== 13 || r_ovl !== 1'b0) begin errors++; $display("FAIL chg3_noDime_timing: got at=%0d ovl=%b expected at=13 ovl=0", r_done_at, r_ovl); end
    run_txn(8'd8, 1'b0, 1'b0, 1, 0);
    checks++; if (r_dime !== 1 || r_nick !== 1) begin errors++; $display("FAIL chg3_coins: got d=%0d n=%0d expected d=1 n=1", r_dime, r_nick); end
    checks++; if (r_done_at !== 10) begin errors++; $display("FAIL chg3_done_at: got %0d expected 10", r_done_at); end
    // Change of 1 must be a nickel even with dimes available.
    run_txn(8'd6, 1'b0, 1'b0, 0, 0);
    checks++; if (r_dime !== 0 || r_nick !== 1 || r_done_at !== 5) begin errors++; $display("FAIL chg1: got d=%0d n=%0d at=%0d expected d=0 n=1 at=5", r_dime, r_nick, r_done_at); end
    // Both hoppers empty: everything becomes shortfall.
    run_txn(8'd7, 1'b1, 1'b1, 0, 0);
    checks++; if (r_short !== 8'd2 || r_dime + r_nick !== 0 || r_done_at !== 3) begin errors++; $display("FAIL both_empty: got short=%0d coins=%0d at=%0d expected short=2 coins=0 at=3", r_short, r_dime + r_nick, r_done_at); end
  endtask

  task automatic test_refund();
    run_txn(8'd3, 1'b0, 1'b1, 0, 2);
    checks++; if (r_can !== 0 || r_dime !== 1 || r_nick !== 0) begin errors++; $display("FAIL refund_coins: got c=%0d d=%0d n=%0d expected c=0 d=1 n=0", r_can, r_dime, r_nick); end
    checks++; if (r_short !== 8'd1 || r_done_at !== 4) begin errors++; $display("FAIL refund_short: got short=%0d at=%0d expected short=1 at=4", r_short, r_done_at); end
    checks++; if (short_n !== 8'd1 || vend_ready !== 1'b1) begin errors++; $display("FAIL refund_short_held: got short=%0d rdy=%b expected short=1 rdy=1", short_n, vend_ready); end
    run_txn(8'd0, 1'b0, 1'b0, 0, 0);
    checks++; if (r_short1 !== 8'd0) begin errors++; $display("FAIL short_cleared_on_accept: got %0d expected 0", r_short1); end
    checks++; if (r_can + r_dime + r_nick !== 0 || r_done_at !== 2) begin errors++; $display("FAIL zero_credit: got reqs=%0d at=%0d expected reqs=0 at=2", r_can + r_dime + r_nick, r_done_at); end
    run_txn(8'd4, 1'b0, 1'b0, 0, 0);
    checks++; if (r_can !== 0 || r_dime !== 2 || r_done_at !== 6) begin errors++; $display("FAIL refund4: got c=%0d d=%0d at=%0d expected c=0 d=2 at=6", r_can, r_dime, r_done_at); end
  endtask

  task automatic test_empty_during_wait();
    dime_empty = 1'b0; nickel_empty = 1'b0;
    vend_valid = 1'b1; credit_n = 8'd7;
    step(); vend_valid = 1'b0;
    can_ack = 1'b1; step(); can_ack = 1'b0;
    step();
    dime_empty = 1'b1;
    step(); step(); step();
    checks++; if (dime_req !== 1'b1 || nickel_req !== 1'b0) begin errors++; $display("FAIL empty_while_wait: got d=%b n=%b expected d=1 n=0", dime_req, nickel_req); end
    dime_ack = 1'b1; step(); dime_ack = 1'b0;
    step(); // SEL
    checks++; if (done !== 1'b1 || short_n !== 8'd0) begin errors++; $display("FAIL empty_while_wait_done: got done=%b short=%0d expected done=1 short=0", done, short_n); end
    dime_empty = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    vend_valid = 1'b1; credit_n = 8'd11;
    step(); vend_valid = 1'b0;
    can_ack = 1'b1; step(); can_ack = 1'b0;
    step(); step(); step();
    checks++; if (dime_req !== 1'b1 || busy !== 1'b1 || vend_ready !== 1'b0) begin errors++; $display("FAIL mid_dime_wait: got d=%b busy=%b rdy=%b expected 1 1 0", dime_req, busy, vend_ready); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if ({can_req, dime_req, nickel_req, busy, done, fault} !== 6'b0 || vend_ready !== 1'b1 || short_n !== 8'd0) begin errors++; $display("FAIL mid_reset: got reqs=%b rdy=%b short=%0d expected 000000 1 0", {can_req, dime_req, nickel_req, busy, done, fault}, vend_ready, short_n); end
    // Change counter was lost: exact price gives no coins.
    run_txn(8'd5, 1'b0, 1'b0, 0, 0);
    checks++; if (r_dime + r_nick !== 0 || r_done_at !== 3) begin errors++; $display("FAIL after_reset_txn: got coins=%0d at=%0d expected 0 3", r_dime + r_nick, r_done_at); end
  endtask

`ifdef COIN_DISPENSE_TIMEOUT_EN
  task automatic test_timeout();
    run_txn(8'd7, 1'b0, 1'b0, 1000, 0);
    checks++; if (r_can !== 15) begin errors++; $display("FAIL timeout_can_cycles: got %0d expected 15", r_can); end
    checks++; if (r_fault !== 1'b1 || r_short !== 8'd7 || r_done !== 1 || r_done_at !== 16) begin errors++; $display("FAIL timeout_result: got fault=%b short=%0d done=%0d at=%0d expected 1 7 1 16", r_fault, r_short, r_done, r_done_at); end
    run_txn(8'd5, 1'b0, 1'b0, 0, 0);
    checks++; if (fault !== 1'b1 || r_done_at !== 3) begin errors++; $display("FAIL timeout_sticky: got fault=%b at=%0d expected 1 3", fault, r_done_at); end
  endtask
`else
  task automatic test_no_timeout();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_tied: got %b expected 0", fault); end
  endtask
`endif

  task automatic test_back_to_back();
    run_txn(8'd10, 1'b0, 1'b0, 0, 0);
    checks++; if (r_dime !== 2 || r_nick !== 1 || r_ovl !== 1'b0) begin errors++; $display("FAIL b2b_first: got d=%0d n=%0d ovl=%b expected 2 1 0", r_dime, r_nick, r_ovl); end
    run_txn(8'd6, 1'b0, 1'b0, 0, 0);
    checks++; if (r_can !== 1 || r_nick !== 1 || r_done_at !== 5) begin errors++; $display("FAIL b2b_second: got c=%0d n=%0d at=%0d expected 1 1 5", r_can, r_nick, r_done_at); end
  endtask

  initial begin
    reset = 1'b1; vend_valid = 1'b0; credit_n = '0;
    can_ack = 1'b0; dime_ack = 1'b0; nickel_ack = 1'b0;
    dime_empty = 1'b0; nickel_empty = 1'b0;
    test_reset();
    test_exact_price();
    test_change();
    test_refund();
    test_empty_during_wait();
    test_reset_mid();
`ifdef COIN_DISPENSE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
